// File: rtl/dot_accum_pkg.sv
// Shared widths, product-stage record and helpers for the dot_accum slice.
// sext_prod returns a wide sign-extended product; callers cast it to their accumulator width.
package dot_accum_pkg;

  localparam int unsigned PROD_W = 4;
  localparam int unsigned X_W    = 2;
  localparam int unsigned W_W    = 2;
  localparam int unsigned SEXT_W = 32;

  typedef struct packed {
    logic                     valid;
    logic                     last;
    logic signed [PROD_W-1:0] prod;
  } prod_stage_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  function automatic logic signed [SEXT_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(SEXT_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/dot_accum_mult.sv
// Unsigned 2-bit activation times signed 2-bit weight, giving a 4-bit signed product (-6..3).
module dot_accum_mult
  import dot_accum_pkg::*;
(
  input  logic        [X_W-1:0]    x,
  input  logic signed [W_W-1:0]    w,
  output logic signed [PROD_W-1:0] prod
);

  logic signed [PROD_W-1:0] xs;
  logic signed [PROD_W-1:0] ws;

  always_comb begin
    xs   = {{(PROD_W-X_W){1'b0}}, x};
    ws   = {{(PROD_W-W_W){w[W_W-1]}}, w};
    prod = xs * ws;
  end

endmodule

// File: rtl/dot_accum.sv
// Streaming dot-product accumulator: registers each product, sums LEN of them,
// and holds the signed result in a one-deep valid/ready output buffer.
module dot_accum
  import dot_accum_pkg::*;
#(
  parameter int LEN   = 16,
  parameter int ACC_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sync_clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic        [X_W-1:0]   in_x,
  input  logic signed [W_W-1:0]   in_w,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum
);

  localparam int unsigned CNT_W = (LEN > 1) ? clog2(LEN) : 1;

  logic signed [PROD_W-1:0] prod;
  prod_stage_t              ps;
  logic        [CNT_W-1:0]  cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum_next;
  logic                     cnt_last;
  logic                     accept;
  logic                     result_wr;

  dot_accum_mult u_mult (
    .x    (in_x),
    .w    (in_w),
    .prod (prod)
  );

  // A last product still in flight also counts as an occupied buffer, so short
  // vectors (LEN <= 2) cannot overwrite a result the consumer has not taken.
  always_comb begin
    cnt_last  = (cnt == CNT_W'(LEN - 1));
    in_ready  = !((out_valid || (ps.valid && ps.last)) && cnt_last);
    accept    = in_valid && in_ready && !sync_clr;
    prod_ext  = ACC_W'(sext_prod(ps.prod));
    sum_next  = acc + prod_ext;
    result_wr = ps.valid && ps.last && !sync_clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps  <= '0;
      cnt <= '0;
    end else if (sync_clr) begin
      ps.valid <= 1'b0;
      cnt      <= '0;
    end else if (accept) begin
      ps.valid <= 1'b1;
      ps.last  <= cnt_last;
      ps.prod  <= prod;
      cnt      <= cnt_last ? '0 : cnt + 1'b1;
    end else begin
      ps.valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (sync_clr) begin
      acc <= '0;
    end else if (ps.valid) begin
      acc <= ps.last ? '0 : sum_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else if (result_wr) begin
      out_valid <= 1'b1;
      out_sum   <= sum_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
